// File: rtl/lcd_spi_pkg.sv
// rtl/lcd_spi_pkg.sv - shared state type, command-field positions and panel opcodes for the LCD SPI transmitter
package lcd_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  localparam int CMD_DC_BIT   = 0;
  localparam int CMD_HOLD_BIT = 1;

  // Opcodes also issued by lcd_draw
  localparam logic [7:0] LCD_CASET = 8'h2A;
  localparam logic [7:0] LCD_RASET = 8'h2B;
  localparam logic [7:0] LCD_RAMWR = 8'h2C;

  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/lcd_spi_tx_if.sv
// rtl/lcd_spi_tx_if.sv - byte request handshake from lcd_draw plus the panel-side SPI pins
interface lcd_spi_tx_if;

  logic       spi_start;
  logic [7:0] spi_data;
  logic [1:0] spi_cmd;
  logic       spi_ready;
  logic       spi_busy;
  logic       spi_byte_done;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs;
  logic       spi_dc;

  modport master (
    output spi_start, spi_data, spi_cmd,
    input  spi_ready, spi_busy, spi_byte_done,
    input  spi_sclk, spi_mosi, spi_cs, spi_dc
  );

  modport slave (
    input  spi_start, spi_data, spi_cmd,
    output spi_ready, spi_busy, spi_byte_done,
    output spi_sclk, spi_mosi, spi_cs, spi_dc
  );

endinterface

// File: rtl/lcd_spi_tx_half_tick.sv
// rtl/lcd_spi_tx_half_tick.sv - restartable divider giving one tick per SCLK half-period
module spi_half_tick
  import lcd_spi_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Restart realigns the count so the cycle after a load is the first of a fresh half-period
  assign o_tick = (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_spi_tx.sv
// rtl/lcd_spi_tx.sv - mode-0 SPI byte transmitter for the LCD panel with one-byte holding buffer and CS-held bursts
module lcd_spi_tx
  import lcd_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input logic         clk,
  input logic         reset,
  lcd_spi_tx_if.slave bus
);

  localparam int GW = cnt_width(CS_GAP);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  spi_state_t r_state, w_state_nx;

  logic          r_buf_full;
  logic          r_ready;
  logic [7:0]    r_buf_data;
  logic [1:0]    r_buf_cmd;

  logic [7:0]    r_shift, w_shift_nx;
  logic          r_mosi, w_mosi_nx;
  logic          r_sclk, w_sclk_nx;
  logic          r_cs, w_cs_nx;
  logic          r_dc, w_dc_nx;
  logic          r_hold, w_hold_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic          r_hi, w_hi_nx;
  logic          r_tail, w_tail_nx;
  logic [GW-1:0] r_gap, w_gap_nx;
  logic          r_done, w_done_nx;

  logic w_tick;
  logic w_load;
  logic w_accept;

  spi_half_tick #(.DIV(CLK_DIV)) u_half_tick (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_load),
    .o_tick    (w_tick)
  );

  assign w_accept = bus.spi_start && r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_buf_full <= 1'b0;
      r_ready    <= 1'b1;
      r_buf_data <= '0;
      r_buf_cmd  <= '0;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
      r_ready    <= 1'b1;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_ready    <= 1'b0;
      r_buf_data <= bus.spi_data;
      r_buf_cmd  <= bus.spi_cmd;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_shift_nx = r_shift;
    w_mosi_nx  = r_mosi;
    w_sclk_nx  = r_sclk;
    w_cs_nx    = r_cs;
    w_dc_nx    = r_dc;
    w_hold_nx  = r_hold;
    w_bit_nx   = r_bit;
    w_hi_nx    = r_hi;
    w_tail_nx  = r_tail;
    w_gap_nx   = r_gap;
    w_done_nx  = 1'b0;
    w_load     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_buf_full) begin
          w_load     = 1'b1;
          w_state_nx = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          w_state_nx = ST_SHIFT;
          w_sclk_nx  = 1'b1;
          w_hi_nx    = 1'b1;
          w_bit_nx   = 3'd0;
          w_tail_nx  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (r_hi) begin
            w_sclk_nx = 1'b0;
            w_hi_nx   = 1'b0;
            if (r_bit != 3'd7) begin
              w_shift_nx = {r_shift[6:0], 1'b0};
              w_mosi_nx  = r_shift[6];
            end else begin
              // Byte boundary: the trailing low half doubles as setup time for a chained byte
              w_done_nx = 1'b1;
              if (!r_hold) begin
                w_tail_nx = 1'b1;
              end else if (r_buf_full) begin
                w_load = 1'b1;
              end else begin
                w_state_nx = ST_HOLD;
              end
            end
          end else if (r_tail) begin
            w_state_nx = ST_GAP;
            w_cs_nx    = 1'b1;
            w_gap_nx   = '0;
          end else begin
            w_sclk_nx = 1'b1;
            w_hi_nx   = 1'b1;
            w_bit_nx  = r_bit + 3'd1;
          end
        end
      end
      ST_HOLD: begin
        if (r_buf_full) begin
          w_load     = 1'b1;
          w_state_nx = ST_SETUP;
        end
      end
      ST_GAP: begin
        if (r_gap == GAP_LAST) begin
          if (r_buf_full) begin
            w_load     = 1'b1;
            w_state_nx = ST_SETUP;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_gap_nx = r_gap + 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cs_nx    = 1'b1;
        w_sclk_nx  = 1'b0;
      end
    endcase

    if (w_load) begin
      w_shift_nx = r_buf_data;
      w_mosi_nx  = r_buf_data[7];
      w_dc_nx    = r_buf_cmd[CMD_DC_BIT];
      w_hold_nx  = r_buf_cmd[CMD_HOLD_BIT];
      w_cs_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_mosi  <= 1'b0;
      r_sclk  <= 1'b0;
      r_cs    <= 1'b1;
      r_dc    <= 1'b0;
      r_hold  <= 1'b0;
      r_bit   <= '0;
      r_hi    <= 1'b0;
      r_tail  <= 1'b0;
      r_gap   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_shift <= w_shift_nx;
      r_mosi  <= w_mosi_nx;
      r_sclk  <= w_sclk_nx;
      r_cs    <= w_cs_nx;
      r_dc    <= w_dc_nx;
      r_hold  <= w_hold_nx;
      r_bit   <= w_bit_nx;
      r_hi    <= w_hi_nx;
      r_tail  <= w_tail_nx;
      r_gap   <= w_gap_nx;
      r_done  <= w_done_nx;
    end
  end

  assign bus.spi_ready     = r_ready;
  assign bus.spi_busy      = (r_state != ST_IDLE);
  assign bus.spi_byte_done = r_done;
  assign bus.spi_sclk      = r_sclk;
  assign bus.spi_mosi      = r_mosi;
  assign bus.spi_cs        = r_cs;
  assign bus.spi_dc        = r_dc;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// tb/tb_lcd_spi_tx.sv - directed bench with an SPI receiver model and scoreboard for lcd_spi_tx
module tb_lcd_spi_tx;
  import lcd_spi_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int CS_GAP  = 2;
  localparam int TMO     = 3000;

  logic clk;
  logic reset;

  lcd_spi_tx_if bus();

  lcd_spi_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected bytes {dc, data} in acceptance order
  logic [8:0] exp_q[$];

  int cyc = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  int last_acc = 0;
  int rise_q[$];
  int frame_q[$];
  int gap_q[$];
  int setup_q[$];
  int fall_q[$];
  logic [7:0] rx_q[$];
  logic rxdc_q[$];

  int rx_n = 0;
  logic [7:0] rx_sh = '0;
  logic rx_dc = 1'b0;
  int cs_lo_run = 0;
  int cs_hi_run = 0;
  bit seen_frame = 0;
  bit setup_pend = 0;
  int fall_cyc = 0;
  bit dc_pend = 0;
  int dc_chg_cyc = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_dc = 1'b0, p_mosi = 1'b0, p_done = 1'b0;

  // Receiver model: a mode-0 slave that samples on SCLK rising edges
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (reset) begin
      rx_n = 0; rx_sh = '0; dc_pend = 0; setup_pend = 0;
      cs_lo_run = 0; cs_hi_run = 0; seen_frame = 0;
    end else begin
      if (bus.spi_dc != p_dc) begin
        chk("dc_change_sclk_low", int'(bus.spi_sclk), 0);
        dc_chg_cyc = cyc;
        dc_pend = 1;
      end
      if (bus.spi_mosi != p_mosi) chk("mosi_change_sclk_low", int'(bus.spi_sclk), 0);
      if (bus.spi_sclk && !p_sclk) begin
        chk("cs_low_at_rise", int'(bus.spi_cs), 0);
        if (dc_pend) begin
          chk("dc_setup_time", int'((cyc - dc_chg_cyc) >= CLK_DIV), 1);
          dc_pend = 0;
        end
        if (setup_pend) begin
          setup_q.push_back(cyc - fall_cyc);
          setup_pend = 0;
        end
        if (rx_n == 0) rx_dc = bus.spi_dc;
        else chk("dc_stable_in_byte", int'(bus.spi_dc), int'(rx_dc));
        rx_sh = {rx_sh[6:0], bus.spi_mosi};
        rx_n++;
        rise_cnt++;
        rise_q.push_back(cyc);
        if (rx_n == 8) begin
          rx_q.push_back(rx_sh);
          rxdc_q.push_back(rx_dc);
          rx_n = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", int'(rx_sh), -1);
          end else begin
            e = exp_q.pop_front();
            chk("byte_data", int'(rx_sh), int'(e[7:0]));
            chk("byte_dc", int'(rx_dc), int'(e[8]));
          end
        end
      end
      if (bus.spi_byte_done) begin
        done_cnt++;
        chk("done_after_full_byte", rx_n, 0);
        chk("done_single_cycle", int'(p_done), 0);
      end
      if (!bus.spi_cs) begin
        if (p_cs) begin
          if (seen_frame) gap_q.push_back(cs_hi_run);
          fall_cyc = cyc;
          fall_q.push_back(cyc);
          setup_pend = 1;
          chk("busy_while_cs_low", int'(bus.spi_busy), 1);
        end
        cs_lo_run++;
        cs_hi_run = 0;
      end else begin
        if (!p_cs) begin
          frame_q.push_back(cs_lo_run);
          seen_frame = 1;
        end
        cs_hi_run++;
        cs_lo_run = 0;
      end
    end
    p_sclk = bus.spi_sclk; p_cs = bus.spi_cs; p_dc = bus.spi_dc;
    p_mosi = bus.spi_mosi; p_done = bus.spi_byte_done;
  end

  task automatic clear_stats();
    @(posedge clk); #1;
    rise_q.delete(); frame_q.delete(); gap_q.delete(); setup_q.delete();
    fall_q.delete(); rx_q.delete(); rxdc_q.delete();
    rise_cnt = 0; done_cnt = 0; seen_frame = 0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] d, input logic [1:0] c);
    int t;
    t = 0;
    bus.spi_start = 1'b1; bus.spi_data = d; bus.spi_cmd = c;
    while (!bus.spi_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) begin
      chk("send_timeout", t, 0);
    end else begin
      @(posedge clk);
      last_acc = cyc;
      exp_q.push_back({c[CMD_DC_BIT], d});
    end
    @(negedge clk);
    chk("ready_low_after_accept", int'(bus.spi_ready), 0);
    bus.spi_start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while ((bus.spi_busy || exp_q.size() != 0) && t < TMO);
    chk("idle_reached", int'(t < TMO), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int acc2;
  logic [7:0] t2_data [3];
  logic       t2_dc   [3];
  logic [7:0] t4_data [4];
  logic [1:0] t4_cmd  [4];

  initial begin
    bus.spi_start = 1'b0; bus.spi_data = '0; bus.spi_cmd = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sclk", int'(bus.spi_sclk), 0);
    chk("rst_mosi", int'(bus.spi_mosi), 0);
    chk("rst_cs", int'(bus.spi_cs), 1);
    chk("rst_dc", int'(bus.spi_dc), 0);
    chk("rst_ready", int'(bus.spi_ready), 1);
    chk("rst_busy", int'(bus.spi_busy), 0);
    chk("rst_byte_done", int'(bus.spi_byte_done), 0);
    @(posedge clk); #2;
    reset = 1'b0;

    // Single non-burst command byte
    clear_stats();
    @(negedge clk);
    send(LCD_CASET, 2'b00);
    @(negedge clk);
    chk("t1_ready_after_load", int'(bus.spi_ready), 1);
    wait_idle();
    chk("t1_frames", frame_q.size(), 1);
    if (frame_q.size() > 0) chk("t1_cs_low_len", frame_q[0], 34);
    if (fall_q.size() > 0) chk("t1_cs_fall_delay", fall_q[0] - last_acc, 2);
    if (setup_q.size() > 0) chk("t1_setup", setup_q[0], CLK_DIV);
    chk("t1_rises", rise_cnt, 8);
    chk("t1_dones", done_cnt, 1);
    chk("t1_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) begin
      chk("t1_rx_byte", int'(rx_q[0]), 8'h2A);
      chk("t1_rx_dc", int'(rxdc_q[0]), 0);
    end

    // CS-held burst: RAMWR then two pixel bytes
    t2_data = '{8'h2C, 8'h00, 8'hF8};
    t2_dc   = '{1'b0, 1'b1, 1'b1};
    clear_stats();
    @(negedge clk);
    send(8'h2C, 2'b10);
    send(8'h00, 2'b11);
    send(8'hF8, 2'b01);
    wait_idle();
    chk("t2_frames", frame_q.size(), 1);
    if (frame_q.size() > 0) chk("t2_cs_low_len", frame_q[0], CLK_DIV + 3 * 16 * CLK_DIV);
    chk("t2_rises", rise_cnt, 24);
    chk("t2_dones", done_cnt, 3);
    for (int i = 1; i < rise_q.size(); i++) chk("t2_rise_spacing", rise_q[i] - rise_q[i-1], 2 * CLK_DIV);
    chk("t2_rx_count", rx_q.size(), 3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      chk("t2_rx_byte", int'(rx_q[i]), int'(t2_data[i]));
      chk("t2_rx_dc", int'(rxdc_q[i]), int'(t2_dc[i]));
    end

    // Hold with an empty buffer for 50 cycles
    clear_stats();
    @(negedge clk);
    send(8'h2C, 2'b10);
    repeat (50) @(negedge clk);
    send(8'h1F, 2'b01);
    acc2 = last_acc;
    wait_idle();
    chk("t3_frames", frame_q.size(), 1);
    chk("t3_rises", rise_cnt, 16);
    // Accept, one edge to load, CLK_DIV setup cycles, then the rise is sampled
    if (rise_q.size() > 8) chk("t3_resume_rise", rise_q[8] - acc2, 2 + CLK_DIV);
    if (setup_q.size() > 0) chk("t3_first_setup", setup_q[0], CLK_DIV);
    chk("t3_rx_count", rx_q.size(), 2);
    if (rx_q.size() > 1) begin
      chk("t3_rx_byte1", int'(rx_q[1]), 8'h1F);
      chk("t3_rx_dc1", int'(rxdc_q[1]), 1);
    end

    // Backpressure: start stays high, data advances only on acceptance
    t4_data = '{8'h81, 8'h7E, 8'hC3, 8'h18};
    t4_cmd  = '{2'b11, 2'b11, 2'b01, 2'b01};
    clear_stats();
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(t4_data[i], t4_cmd[i]);
    wait_idle();
    chk("t4_rx_count", rx_q.size(), 4);
    chk("t4_dones", done_cnt, 4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("t4_rx_byte", int'(rx_q[i]), int'(t4_data[i]));
    chk("t4_frames", frame_q.size(), 2);
    if (frame_q.size() > 1) begin
      chk("t4_frame0_len", frame_q[0], 49 * CLK_DIV);
      chk("t4_frame1_len", frame_q[1], 17 * CLK_DIV);
    end
    if (gap_q.size() > 0) chk("t4_gap", gap_q[0], CS_GAP);

    // Two independent data frames
    clear_stats();
    @(negedge clk);
    send(8'h55, 2'b01);
    send(8'hAA, 2'b01);
    wait_idle();
    chk("t5_frames", frame_q.size(), 2);
    for (int i = 0; i < frame_q.size(); i++) chk("t5_frame_len", frame_q[i], 34);
    chk("t5_gaps", gap_q.size(), 1);
    if (gap_q.size() > 0) chk("t5_gap_len", gap_q[0], 2);
    chk("t5_setups", setup_q.size(), 2);
    for (int i = 0; i < setup_q.size(); i++) chk("t5_setup_len", setup_q[i], 2);
    chk("t5_rises", rise_cnt, 16);
    if (rx_q.size() > 1) begin
      chk("t5_rx_byte0", int'(rx_q[0]), 8'h55);
      chk("t5_rx_byte1", int'(rx_q[1]), 8'hAA);
    end

    // Reset in the middle of a byte
    clear_stats();
    @(negedge clk);
    send(8'hA5, 2'b01);
    begin
      int t;
      t = 0;
      while (rise_cnt < 3 && t < TMO) begin
        @(posedge clk); #2;
        t++;
      end
      chk("t6_third_rise_seen", int'(t < TMO), 1);
    end
    reset = 1'b1;
    #1;
    chk("t6_rst_cs", int'(bus.spi_cs), 1);
    chk("t6_rst_sclk", int'(bus.spi_sclk), 0);
    chk("t6_rst_ready", int'(bus.spi_ready), 1);
    chk("t6_rst_busy", int'(bus.spi_busy), 0);
    chk("t6_rst_mosi", int'(bus.spi_mosi), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    clear_stats();
    @(negedge clk);
    send(8'h3C, 2'b01);
    wait_idle();
    chk("t6_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("t6_rx_byte", int'(rx_q[0]), 8'h3C);
    chk("t6_dones", done_cnt, 1);
    if (frame_q.size() > 0) chk("t6_frame_len", frame_q[0], 34);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
